aes_pio_sequencer: RTL

AES_PIO_SEQUENCER -- requirements
Module: aes_pio_sequencer

---
 rtl/aes_pio_sequencer_if.sv | 27 ++
 rtl/aes_pio_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/aes_pio_sequencer_if.sv
// Avalon-MM slave bus bundle for the AES PIO sequencer register file.
// Latency: none (wires only).
// Backpressure: none; the bus has no waitrequest, so every access completes in one cycle.
//
// Signals:
//   address    [2:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe, qualified by chipselect
//   writedata  [31:0] write data
//   readdata   [31:0] combinational read data
interface aes_pio_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/aes_pio_sequencer.sv
// Register front-end that sequences one AES block operation per START command.
// Latency: START write at edge N -> aes_start in cycle N+1; aes_done in cycle M -> done/idle from cycle M+2.
// Backpressure: none; writes to input words and START are dropped while busy, and a stuck core times out.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   avs (slave modport)  Avalon-MM register bus (address/chipselect/write_n/writedata/readdata)
//   aes_data_in  [127:0] input block to the core (word k at bits 32k+31:32k)
//   aes_start            one-cycle start pulse to the core
//   aes_done             core completion strobe, aes_data_out valid in the same cycle
//   aes_data_out [127:0] result block from the core
//   irq                  level interrupt
//
// Register map: 0-3 input words (W) / result words (R), 4 CTRL (W) / STATUS (R),
//               5 completed-block counter (R), 6-7 read as zero.
//
// Build option: define AES_PIO_SEQUENCER_IRQ_EN to enable the registered interrupt
// irq = (done | error) & IRQ_ENA; otherwise irq is tied low and CTRL bit2 is ignored.
module aes_pio_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024  // legal range 2..65535
) (
  input  logic                clk,
  input  logic                reset_n,
  aes_pio_sequencer_if.slave  avs,
  output logic [127:0]        aes_data_in,
  output logic                aes_start,
  input  logic                aes_done,
  input  logic [127:0]        aes_data_out,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic [127:0] in_w;
  logic [127:0] res_w;
  logic [31:0]  blk_cnt;
  logic [15:0]  tmo_cnt;
  logic         done;
  logic         error;
  logic         busy;
  logic         wr_en;
  logic         ctrl_wr;

  assign wr_en       = avs.chipselect & ~avs.write_n;
  assign ctrl_wr     = wr_en && (avs.address == 3'd4);
  assign busy        = (state != S_IDLE);
  assign aes_data_in = in_w;

  // The clear from CTRL bit1 is applied before the FSM's set of done/error so
  // that a set landing on the same edge takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      in_w      <= '0;
      res_w     <= '0;
      blk_cnt   <= '0;
      tmo_cnt   <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      aes_start <= 1'b0;
    end else begin
      aes_start <= 1'b0;

      if (ctrl_wr && avs.writedata[1]) begin
        done  <= 1'b0;
        error <= 1'b0;
      end

      // Input words are frozen while a block is in flight.
      if (wr_en && !busy && !avs.address[2]) begin
        in_w[{avs.address[1:0], 5'd0} +: 32] <= avs.writedata;
      end

      case (state)
        S_IDLE: begin
          if (ctrl_wr && avs.writedata[0]) begin
            state     <= S_START;
            aes_start <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (aes_done) begin
            // Result is taken while aes_data_out is still valid.
            res_w <= aes_data_out;
            state <= S_CAPTURE;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_IDLE;
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
          done    <= 1'b1;
          blk_cnt <= blk_cnt + 32'd1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    avs.readdata = 32'h0;
    case (avs.address)
      3'd0, 3'd1, 3'd2, 3'd3: avs.readdata = res_w[{avs.address[1:0], 5'd0} +: 32];
      3'd4:                   avs.readdata = {29'd0, error, done, busy};
      3'd5:                   avs.readdata = blk_cnt;
      default:                avs.readdata = 32'h0;
    endcase
  end

`ifdef AES_PIO_SEQUENCER_IRQ_EN
  logic irq_ena;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_ena <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_ena <= avs.writedata[2];
      end
      irq <= (done | error) & irq_ena;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
